reset_receiver: RTL

Receiving end of a generated-reset link: consumes an active-low reset driven from another clock domain or reset generator (`IN_RST`) and re-issues it as a local active-low reset (`OUT_RST`) on `CLK`. Assertion is asynchronous. Deassertion is synchronized through a flop chain and then stretched by a programmable hold count. The block sits at the clock-domain boundary, in front of every register bank fed by a foreign reset.

---
 rtl/reset_receiver.sv | 110 +++++++++++
 1 files changed

// File: rtl/reset_receiver.sv
// reset_receiver: re-issues a foreign active-low reset on CLK with async assert, synchronized and held release.
// Optional saturating release counter is enabled by defining RESET_RECEIVER_EVENT_CNT_EN.
`timescale 1ns/1ps
module reset_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_RST,
    output logic       OUT_RST,
    output logic       ASSERT_OUT,
    output logic [7:0] EVENT_CNT
);
    localparam int            CW        = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

    // One-hot encoding; the RUN bit itself is the OUT_RST flop.
    typedef enum logic [2:0] {
        ST_ASSERT = 3'b001,
        ST_HOLD   = 3'b010,
        ST_RUN    = 3'b100
    } state_t;
    localparam int RUN_BIT = 2;

    logic                   w_aclr_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;

    assign w_aclr_n = RST & IN_RST;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge w_aclr_n) begin
        if (!w_aclr_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge w_aclr_n) begin
        if (!w_aclr_n) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first keep this block free of inferred latches.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ASSERT: begin
                if (w_s) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        OUT_RST    = r_state[RUN_BIT];
        ASSERT_OUT = ~r_state[RUN_BIT];
    end

`ifdef RESET_RECEIVER_EVENT_CNT_EN
    logic       w_release;
    logic [7:0] r_event_cnt;

    assign w_release = (r_state == ST_HOLD) && (w_state_nxt == ST_RUN);

    // Cleared by the local reset only, so it survives incoming reset pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_event_cnt <= '0;
        end else if (w_release && (r_event_cnt != 8'hFF)) begin
            r_event_cnt <= r_event_cnt + 8'd1;
        end
    end

    assign EVENT_CNT = r_event_cnt;
`else
    assign EVENT_CNT = 8'd0;
`endif

endmodule
